// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/writeback
// steps, drives datapath selects and strobes, and counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_HANDSHAKE   = 1,
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_we,
  output logic             mem_re,
  output logic             reg_we,
  output logic             adr_src,
  output logic [1:0]       alu_a_src,
  output logic [1:0]       alu_b_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t cur, nxt;
  logic   ready;
  logic   taken;
  logic   legal;
  logic   retire;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_BRANCH:                         legal = (funct3[2:1] != 2'b01);
      default:                           legal = 1'b0;
    endcase
  end

  // A store retires only on the cycle its write is accepted.
  assign retire = (cur == S_MEMWB) || (cur == S_ALUWB) || (cur == S_BRANCH) ||
                  ((cur == S_MEMWRITE) && ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    nxt        = cur;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    alu_a_src  = 2'b00;
    alu_b_src  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_re     = 1'b1;
        alu_b_src  = 2'b10;
        result_src = 2'b10;
        pc_we      = ready;
        ir_we      = ready;
        if (ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_a_src = 2'b01;
        alu_b_src = 2'b01;
        if (!legal) begin
          nxt = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_RTYPE:          nxt = S_EXECR;
            OP_ITYPE:          nxt = S_EXECI;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           nxt = S_JALR_ADR;
            OP_LUI:            nxt = S_LUI;
            OP_AUIPC:          nxt = S_AUIPC;
            default:           nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        nxt       = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        mem_re  = 1'b1;
        if (ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
        if (ready) nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_a_src = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXECI: begin
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_src = 2'b10;
        alu_op    = 2'b01;
        pc_we     = taken;
        nxt       = S_FETCH;
      end
      // The jump target already sits in ALU-out; the ALU forms the link value.
      S_JAL, S_JALR: begin
        alu_a_src = 2'b01;
        alu_b_src = 2'b10;
        pc_we     = 1'b1;
        nxt       = S_ALUWB;
      end
      S_JALR_ADR: begin
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        nxt       = S_JALR;
      end
      S_LUI: begin
        alu_a_src = 2'b11;
        alu_b_src = 2'b01;
        nxt       = S_ALUWB;
      end
      S_AUIPC: begin
        alu_a_src = 2'b01;
        alu_b_src = 2'b01;
        nxt       = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        nxt     = S_TRAP;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule
